// File: rtl/multi_wave_gen_pkg.sv
// Shared types for the multi-waveform generator.
// - wave_mode_e : selects which waveform the sample output carries.
// - wave_cfg_t  : one complete configuration (tuning word, duty threshold, mode).
//   Step and duty are CFG_PHASE_W bits wide, the widest phase accumulator
//   supported. A narrower generator zero-extends into these fields.
package wave_gen_pkg;

  localparam int CFG_PHASE_W = 16;

  typedef enum logic [1:0] {
    MODE_SQUARE = 2'd0,
    MODE_SAW    = 2'd1,
    MODE_TRI    = 2'd2,
    MODE_OFF    = 2'd3
  } wave_mode_e;

  typedef struct packed {
    logic [CFG_PHASE_W-1:0] step;
    logic [CFG_PHASE_W-1:0] duty;
    wave_mode_e             mode;
  } wave_cfg_t;

endpackage

// File: rtl/multi_wave_gen_phase.sv
// Phase accumulator for the waveform generator.
// Ports:
//   clk, rst : clock and synchronous active-high reset
//   ena      : add step to the phase this cycle
//   clr      : force phase to zero (wins over ena)
//   step     : phase increment (tuning word)
//   phase    : registered phase value
//   carry    : combinational, high when this cycle's update overflows;
//              the parent uses it as the period boundary
module phase_accumulator #(
  parameter int PHASE_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ena,
  input  logic               clr,
  input  logic [PHASE_W-1:0] step,
  output logic [PHASE_W-1:0] phase,
  output logic               carry
);

  logic [PHASE_W-1:0] phase_q;
  logic [PHASE_W-1:0] phase_d;
  logic [PHASE_W:0]   sum;

  assign sum   = {1'b0, phase_q} + {1'b0, step};
  assign carry = ena && !clr && !rst && sum[PHASE_W];
  assign phase = phase_q;

  always_comb begin
    phase_d = phase_q;
    if (clr) begin
      phase_d = '0;
    end else if (ena) begin
      phase_d = sum[PHASE_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q <= '0;
    end else begin
      phase_q <= phase_d;
    end
  end

endmodule

// File: rtl/multi_wave_gen.sv
// Multi-waveform generator: square (programmable duty), sawtooth, triangle.
// A phase accumulator advances by the active tuning word; a new configuration
// offered on the valid/ready port is held as pending and only swapped into
// the active set at a period boundary (carry), on sync, or at once when the
// active step is zero (generator frozen, so no glitch is possible).
// Ports:
//   clk, rst     : clock and synchronous active-high reset
//   ena_i        : advance phase this cycle
//   sync_i       : zero the phase and apply any pending config now
//   cfg_valid_i  : config offer; cfg_ready_o : pending slot is free
//   cfg_step_i   : tuning word; cfg_duty_i : square threshold; cfg_mode_i : wave_mode_e
//   wave_o       : registered sample; sq_o : registered square line
//   wrap_o       : registered one-cycle pulse when the phase carried
module multi_wave_gen
  import wave_gen_pkg::*;
#(
  parameter int PHASE_W = 16,
  parameter int OUT_W   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ena_i,
  input  logic               sync_i,
  input  logic               cfg_valid_i,
  output logic               cfg_ready_o,
  input  logic [PHASE_W-1:0] cfg_step_i,
  input  logic [PHASE_W-1:0] cfg_duty_i,
  input  logic [1:0]         cfg_mode_i,
  output logic [OUT_W-1:0]   wave_o,
  output logic               sq_o,
  output logic               wrap_o
);

  if (OUT_W < 1 || OUT_W > PHASE_W - 1) begin : g_badOutW
    $error("multi_wave_gen: OUT_W must satisfy 1 <= OUT_W <= PHASE_W-1");
  end
  if (PHASE_W > CFG_PHASE_W) begin : g_badPhaseW
    $error("multi_wave_gen: PHASE_W exceeds wave_gen_pkg::CFG_PHASE_W");
  end

  wave_cfg_t          activeCfg_q, activeCfg_d;
  wave_cfg_t          pendingCfg_q, pendingCfg_d;
  logic               pendingValid_q, pendingValid_d;
  wave_cfg_t          offerCfg;
  logic               accept;
  logic               apply;
  logic               stepZero;

  logic [PHASE_W-1:0] phase;
  logic               carry;

  logic [OUT_W-1:0]   wave_q, wave_d;
  logic               sq_q, sq_d;
  logic               wrap_q;

  logic [CFG_PHASE_W-1:0] phaseExt;
  logic [OUT_W-1:0]       topBits;
  logic [OUT_W-1:0]       triBits;

  phase_accumulator #(
    .PHASE_W (PHASE_W)
  ) u_phase (
    .clk   (clk),
    .rst   (rst),
    .ena   (ena_i),
    .clr   (sync_i),
    .step  (activeCfg_q.step[PHASE_W-1:0]),
    .phase (phase),
    .carry (carry)
  );

  // Config handshake. Apply only drains a config already pending, so an
  // offer accepted in a carry cycle waits for the following boundary.
  always_comb begin
    offerCfg                   = '0;
    offerCfg.step[PHASE_W-1:0] = cfg_step_i;
    offerCfg.duty[PHASE_W-1:0] = cfg_duty_i;
    offerCfg.mode              = wave_mode_e'(cfg_mode_i);

    stepZero = (activeCfg_q.step == '0);
    accept   = cfg_valid_i && !pendingValid_q;
    apply    = pendingValid_q && (carry || sync_i || stepZero);

    activeCfg_d    = activeCfg_q;
    pendingCfg_d   = pendingCfg_q;
    pendingValid_d = pendingValid_q;

    if (apply) begin
      activeCfg_d    = pendingCfg_q;
      pendingValid_d = 1'b0;
    end
    if (accept) begin
      pendingCfg_d   = offerCfg;
      pendingValid_d = 1'b1;
    end
  end

  // Output decode from the current phase register and active config; the
  // result is registered, giving one cycle of latency from the phase.
  always_comb begin
    phaseExt                = '0;
    phaseExt[PHASE_W-1:0]   = phase;
    topBits                 = phase[PHASE_W-1 -: OUT_W];
    triBits                 = phase[PHASE_W-2 -: OUT_W];

    sq_d   = (phaseExt < activeCfg_q.duty);
    wave_d = '0;
    case (activeCfg_q.mode)
      MODE_SQUARE: wave_d = sq_d ? {OUT_W{1'b1}} : '0;
      MODE_SAW:    wave_d = topBits;
      MODE_TRI:    wave_d = phase[PHASE_W-1] ? ~triBits : triBits;
      default:     wave_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      activeCfg_q    <= '{step: '0, duty: '0, mode: MODE_OFF};
      pendingCfg_q   <= '{step: '0, duty: '0, mode: MODE_OFF};
      pendingValid_q <= 1'b0;
      wave_q         <= '0;
      sq_q           <= 1'b0;
      wrap_q         <= 1'b0;
    end else begin
      activeCfg_q    <= activeCfg_d;
      pendingCfg_q   <= pendingCfg_d;
      pendingValid_q <= pendingValid_d;
      wave_q         <= wave_d;
      sq_q           <= sq_d;
      wrap_q         <= carry;
    end
  end

  assign cfg_ready_o = !pendingValid_q;
  assign wave_o      = wave_q;
  assign sq_o        = sq_q;
  assign wrap_o      = wrap_q;

endmodule

// File: tb/tb_multi_wave_gen.sv
// Directed testbench for multi_wave_gen at PHASE_W=8, OUT_W=4.
module tb_multi_wave_gen;

  localparam logic [1:0] M_SQUARE = 2'd0;
  localparam logic [1:0] M_SAW    = 2'd1;
  localparam logic [1:0] M_TRI    = 2'd2;

  logic       clk = 1'b0;
  logic       rst;
  logic       ena;
  logic       sync;
  logic       cfgValid;
  logic       cfgReady;
  logic [7:0] cfgStep;
  logic [7:0] cfgDuty;
  logic [1:0] cfgMode;
  logic [3:0] wave;
  logic       sq;
  logic       wrap;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  multi_wave_gen #(
    .PHASE_W (8),
    .OUT_W   (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .ena_i       (ena),
    .sync_i      (sync),
    .cfg_valid_i (cfgValid),
    .cfg_ready_o (cfgReady),
    .cfg_step_i  (cfgStep),
    .cfg_duty_i  (cfgDuty),
    .cfg_mode_i  (cfgMode),
    .wave_o      (wave),
    .sq_o        (sq),
    .wrap_o      (wrap)
  );

  // Expected triangle sample for an 8-bit phase, 4-bit output.
  function automatic logic [3:0] triOf(input logic [7:0] p);
    logic [3:0] t;
    t = p[6:3];
    return p[7] ? ~t : t;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer a config, then sync so it is applied with phase at zero.
  task automatic loadCfg(input logic [7:0] s, input logic [7:0] d, input logic [1:0] m);
    int n;
    ena  = 1'b0;
    sync = 1'b0;
    n    = 0;
    while (!cfgReady && n < 50) begin
      tick();
      n++;
    end
    if (!cfgReady) begin
      checks++;
      errors++;
      $display("[TB] FAIL load_ready_timeout got=%0b want=1", cfgReady);
    end
    cfgStep  = s;
    cfgDuty  = d;
    cfgMode  = m;
    cfgValid = 1'b1;
    tick();
    cfgValid = 1'b0;
    sync     = 1'b1;
    tick();
    sync     = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; ena = 1'b0; sync = 1'b0; cfgValid = 1'b0;
    cfgStep = '0; cfgDuty = '0; cfgMode = '0;
    repeat (3) tick();
    checks++;
    if ({wave, sq, wrap, cfgReady} !== {4'd0, 1'b0, 1'b0, 1'b1}) begin
      errors++;
      $display("[TB] FAIL reset_state got wave=%0d sq=%0b wrap=%0b rdy=%0b want 0 0 0 1",
               wave, sq, wrap, cfgReady);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_square();
    loadCfg(8'd32, 8'd128, M_SQUARE);
    ena = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      logic       expSq;
      logic       expWrap;
      tick();
      expSq   = ((k - 1) % 8) < 4;
      expWrap = (k % 8) == 0;
      checks++;
      if (sq !== expSq || wave !== (expSq ? 4'd15 : 4'd0) || wrap !== expWrap) begin
        errors++;
        $display("[TB] FAIL square k=%0d got sq=%0b wave=%0d wrap=%0b want sq=%0b wrap=%0b",
                 k, sq, wave, wrap, expSq, expWrap);
      end
    end
  endtask

  task automatic test_saw();
    loadCfg(8'd16, 8'd0, M_SAW);
    ena = 1'b1;
    for (int k = 1; k <= 32; k++) begin
      logic [3:0] expWave;
      logic       expWrap;
      tick();
      expWave = 4'((k - 1) % 16);
      expWrap = (k % 16) == 0;
      checks++;
      if (wave !== expWave || wrap !== expWrap) begin
        errors++;
        $display("[TB] FAIL saw k=%0d got wave=%0d wrap=%0b want wave=%0d wrap=%0b",
                 k, wave, wrap, expWave, expWrap);
      end
    end
  endtask

  task automatic test_tri();
    loadCfg(8'd16, 8'd0, M_TRI);
    ena = 1'b1;
    for (int k = 1; k <= 17; k++) begin
      logic [3:0] expWave;
      tick();
      expWave = triOf(8'((16 * (k - 1)) % 256));
      checks++;
      if (wave !== expWave) begin
        errors++;
        $display("[TB] FAIL tri k=%0d got wave=%0d want wave=%0d", k, wave, expWave);
      end
    end
  endtask

  task automatic test_duty_bounds();
    loadCfg(8'd32, 8'd0, M_SQUARE);
    ena = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      checks++;
      if (sq !== 1'b0 || wave !== 4'd0) begin
        errors++;
        $display("[TB] FAIL duty_zero k=%0d got sq=%0b wave=%0d want 0 0", k, sq, wave);
      end
    end
    loadCfg(8'd1, 8'd255, M_SQUARE);
    ena = 1'b1;
    for (int k = 1; k <= 257; k++) begin
      logic expSq;
      logic expWrap;
      tick();
      expSq   = ((k - 1) % 256) != 255;
      expWrap = (k % 256) == 0;
      checks++;
      if (sq !== expSq || wrap !== expWrap) begin
        errors++;
        $display("[TB] FAIL duty_max k=%0d got sq=%0b wrap=%0b want sq=%0b wrap=%0b",
                 k, sq, wrap, expSq, expWrap);
      end
    end
  endtask

  // Swap at the carry, then an offer landing exactly on a carry cycle.
  task automatic test_back_to_back();
    loadCfg(8'd32, 8'd128, M_SQUARE);
    ena = 1'b1;
    repeat (3) tick();
    checks++;
    if (cfgReady !== 1'b1) begin
      errors++;
      $display("[TB] FAIL b2b_ready_before got=%0b want=1", cfgReady);
    end
    cfgStep = 8'd64; cfgDuty = 8'd0; cfgMode = M_SAW; cfgValid = 1'b1;
    tick();
    cfgValid = 1'b0;
    for (int k = 4; k <= 7; k++) begin
      if (k > 4) tick();
      checks++;
      if (cfgReady !== 1'b0) begin
        errors++;
        $display("[TB] FAIL b2b_ready_held k=%0d got=%0b want=0", k, cfgReady);
      end
    end
    tick();
    checks++;
    if (cfgReady !== 1'b1 || wrap !== 1'b1) begin
      errors++;
      $display("[TB] FAIL b2b_apply got rdy=%0b wrap=%0b want 1 1", cfgReady, wrap);
    end
    tick();
    checks++;
    if (wave !== 4'd0) begin
      errors++;
      $display("[TB] FAIL b2b_phase0 got wave=%0d want 0", wave);
    end
    tick();
    checks++;
    if (wave !== 4'd4) begin
      errors++;
      $display("[TB] FAIL b2b_phase64 got wave=%0d want 4", wave);
    end
    tick();
    checks++;
    if (wave !== 4'd8) begin
      errors++;
      $display("[TB] FAIL b2b_phase128 got wave=%0d want 8", wave);
    end
    cfgStep = 8'd16; cfgDuty = 8'd0; cfgMode = M_SAW; cfgValid = 1'b1;
    tick();
    cfgValid = 1'b0;
    checks++;
    if (wrap !== 1'b1 || cfgReady !== 1'b0) begin
      errors++;
      $display("[TB] FAIL nobypass_capture got wrap=%0b rdy=%0b want 1 0", wrap, cfgReady);
    end
    tick();
    tick();
    checks++;
    if (wave !== 4'd4 || cfgReady !== 1'b0) begin
      errors++;
      $display("[TB] FAIL nobypass_oldstep got wave=%0d rdy=%0b want 4 0", wave, cfgReady);
    end
    tick();
    tick();
    checks++;
    if (cfgReady !== 1'b1 || wrap !== 1'b1) begin
      errors++;
      $display("[TB] FAIL nobypass_apply got rdy=%0b wrap=%0b want 1 1", cfgReady, wrap);
    end
    tick();
    tick();
    checks++;
    if (wave !== 4'd1) begin
      errors++;
      $display("[TB] FAIL nobypass_newstep got wave=%0d want 1", wave);
    end
  endtask

  task automatic test_hold_sync();
    loadCfg(8'd32, 8'd128, M_SAW);
    ena = 1'b1;
    repeat (3) tick();
    ena = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      tick();
      checks++;
      if (wave !== 4'd6 || wrap !== 1'b0) begin
        errors++;
        $display("[TB] FAIL hold i=%0d got wave=%0d wrap=%0b want 6 0", i, wave, wrap);
      end
      if (i == 1) begin
        cfgStep = 8'd16; cfgDuty = 8'd0; cfgMode = M_SAW; cfgValid = 1'b1;
      end else begin
        cfgValid = 1'b0;
      end
    end
    checks++;
    if (cfgReady !== 1'b0) begin
      errors++;
      $display("[TB] FAIL hold_pending got rdy=%0b want 0", cfgReady);
    end
    sync = 1'b1;
    tick();
    sync = 1'b0;
    checks++;
    if (cfgReady !== 1'b1 || wrap !== 1'b0) begin
      errors++;
      $display("[TB] FAIL sync_apply got rdy=%0b wrap=%0b want 1 0", cfgReady, wrap);
    end
    ena = 1'b1;
    tick();
    checks++;
    if (wave !== 4'd0) begin
      errors++;
      $display("[TB] FAIL sync_phase0 got wave=%0d want 0", wave);
    end
    tick();
    checks++;
    if (wave !== 4'd1) begin
      errors++;
      $display("[TB] FAIL sync_newstep got wave=%0d want 1", wave);
    end
  endtask

  task automatic test_rst_midrun();
    loadCfg(8'd32, 8'd128, M_SQUARE);
    ena = 1'b1;
    repeat (2) tick();
    cfgStep = 8'd16; cfgDuty = 8'd0; cfgMode = M_SAW; cfgValid = 1'b1;
    tick();
    cfgValid = 1'b0;
    checks++;
    if (cfgReady !== 1'b0) begin
      errors++;
      $display("[TB] FAIL rst_pending_before got rdy=%0b want 0", cfgReady);
    end
    rst = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      tick();
      checks++;
      if ({wave, sq, wrap, cfgReady} !== {4'd0, 1'b0, 1'b0, 1'b1}) begin
        errors++;
        $display("[TB] FAIL rst_midrun i=%0d got wave=%0d sq=%0b wrap=%0b rdy=%0b want 0 0 0 1",
                 i, wave, sq, wrap, cfgReady);
      end
    end
    rst = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      checks++;
      if ({wave, sq, wrap, cfgReady} !== {4'd0, 1'b0, 1'b0, 1'b1}) begin
        errors++;
        $display("[TB] FAIL rst_discard i=%0d got wave=%0d sq=%0b wrap=%0b rdy=%0b want 0 0 0 1",
                 i, wave, sq, wrap, cfgReady);
      end
    end
  endtask

  initial begin
    test_reset();
    test_square();
    test_saw();
    test_tri();
    test_duty_bounds();
    test_back_to_back();
    test_hold_sync();
    test_rst_midrun();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
